// File: rtl/uart_rx_apb_poller.sv
// uart_rx_apb_poller: APB manager that configures a UART receive register
// block, polls it for received bytes and buffers them in a show-ahead FIFO.
module uart_rx_apb_poller #(
  parameter logic [13:0] BIT_PERIOD = 14'd10,
  parameter logic [3:0]  DATA_SIZE  = 4'd8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned POLL_GAP   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       psel,
  output logic       penable,
  output logic       pwrite,
  output logic [2:0] paddr,
  output logic [7:0] pwdata,
  input  logic [7:0] prdata,
  input  logic       psaterr,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [2:0] err_flags,
  input  logic       err_clear,
  output logic       cfg_done,
  output logic       busy
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  localparam logic [2:0] ADDR_STAT  = 3'd0;
  localparam logic [2:0] ADDR_ERR   = 3'd1;
  localparam logic [2:0] ADDR_BP_LO = 3'd2;
  localparam logic [2:0] ADDR_BP_HI = 3'd3;
  localparam logic [2:0] ADDR_DSIZE = 3'd4;
  localparam logic [2:0] ADDR_DATA  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE, S_CFG_BP1, S_CFG_BP2, S_CFG_DS,
    S_POLL_STAT, S_RD_ERR, S_RD_DATA, S_GAP
  } state_e;

  state_e          state_q, state_d;
  logic            phase_q, phase_d;     // 0 = SETUP, 1 = ACCESS
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            cfg_done_q, cfg_done_d;
  logic [2:0]      err_q, err_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic in_xfer;
  logic access_cyc;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;

  assign in_xfer    = (state_q != S_IDLE) && (state_q != S_GAP);
  assign access_cyc = in_xfer && phase_q;
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = (state_q == S_RD_DATA) && phase_q;
  assign pop        = rx_ready && !fifo_empty;

  // State register and datapath flops; reset aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      phase_q    <= 1'b0;
      gap_cnt_q  <= '0;
      cfg_done_q <= 1'b0;
      err_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      gap_cnt_q  <= gap_cnt_d;
      cfg_done_q <= cfg_done_d;
      err_q      <= err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage captures the data read at the end of the RD_DATA access.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= prdata;
  end

  // Next-state: each transfer state spends one SETUP and one ACCESS cycle.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      S_IDLE: begin
        phase_d = 1'b0;
        if (enable) state_d = S_CFG_BP1;
      end
      S_GAP: begin
        if (gap_cnt_q == GW'(POLL_GAP - 1)) begin
          gap_cnt_d = '0;
          state_d   = enable ? S_POLL_STAT : S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          case (state_q)
            S_CFG_BP1:   state_d = S_CFG_BP2;
            S_CFG_BP2:   state_d = S_CFG_DS;
            S_CFG_DS:    state_d = S_POLL_STAT;
            S_POLL_STAT: state_d = prdata[0] ? S_RD_ERR : S_GAP;
            // A full FIFO leaves the byte in the UART for a later round.
            S_RD_ERR:    state_d = fifo_full ? S_GAP : S_RD_DATA;
            S_RD_DATA:   state_d = S_GAP;
            default:     state_d = S_IDLE;
          endcase
        end
      end
    endcase
  end

  // APB outputs decoded from the state; everything is zero between transfers.
  always_comb begin
    psel   = 1'b0;
    pwrite = 1'b0;
    paddr  = '0;
    pwdata = '0;
    case (state_q)
      S_CFG_BP1:   begin psel = 1'b1; pwrite = 1'b1; paddr = ADDR_BP_LO; pwdata = BIT_PERIOD[7:0]; end
      S_CFG_BP2:   begin psel = 1'b1; pwrite = 1'b1; paddr = ADDR_BP_HI; pwdata = {2'b00, BIT_PERIOD[13:8]}; end
      S_CFG_DS:    begin psel = 1'b1; pwrite = 1'b1; paddr = ADDR_DSIZE; pwdata = {4'b0000, DATA_SIZE}; end
      S_POLL_STAT: begin psel = 1'b1; paddr = ADDR_STAT; end
      S_RD_ERR:    begin psel = 1'b1; paddr = ADDR_ERR; end
      S_RD_DATA:   begin psel = 1'b1; paddr = ADDR_DATA; end
      default:     ;
    endcase
    penable = psel && phase_q;
  end

  // Sticky flags, config-done latch and FIFO pointer bookkeeping.
  always_comb begin
    cfg_done_d = cfg_done_q || ((state_q == S_CFG_DS) && phase_q);
    // Clear first so an error arriving in the same cycle survives.
    err_d = err_clear ? 3'b000 : err_q;
    if (access_cyc && psaterr) err_d[2] = 1'b1;
    if ((state_q == S_RD_ERR) && phase_q) err_d[1:0] = err_d[1:0] | prdata[1:0];
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  assign rx_byte   = mem_q[rd_ptr_q];
  assign rx_valid  = !fifo_empty;
  assign err_flags = err_q;
  assign cfg_done  = cfg_done_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_apb_poller.sv
// tb_uart_rx_apb_poller: randomized bench with a transaction-level model of
// the poller; expected APB transfers and bytes are queued and checked by a
// separate monitor.
module tb_uart_rx_apb_poller;

  localparam int DEPTH = 4;
  localparam int GAP   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       psel, penable, pwrite;
  logic [2:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata = 8'h00;
  logic       psaterr = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [2:0] err_flags;
  logic       err_clear = 1'b0;
  logic       cfg_done, busy;

  always #5 clk = ~clk;

  uart_rx_apb_poller #(
    .BIT_PERIOD(14'd10), .DATA_SIZE(4'd8), .FIFO_DEPTH(DEPTH), .POLL_GAP(GAP)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .psaterr(psaterr),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .err_flags(err_flags), .err_clear(err_clear),
    .cfg_done(cfg_done), .busy(busy)
  );

  typedef struct {
    bit         wr;
    logic [2:0] addr;
    logic [7:0] data;
    int         setup;
  } xfer_t;

  int checks = 0;
  int errors = 0;

  xfer_t      apb_exp[$];   // expected transfers, oldest first
  logic [7:0] exp_q[$];     // bytes expected at the consumer, in order
  logic [7:0] uart_q[$];    // bytes waiting inside the modelled UART
  logic [7:0] err_reg = 8'h00;
  logic       inj_saterr = 1'b0;

  // Reference model state
  int         cyc = 0;
  int         m_ph = 0;     // 0 idle, 1 transfer scheduled, 2 gap
  int         gap_end = 0;
  int         m_cnt = 0;
  int         m_push = 0;
  int         m_pop = 0;
  int         drop = 0;
  logic [2:0] m_err = 3'b000;
  logic       m_cfg = 1'b0;
  bit         live = 1'b0;
  xfer_t      cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic sched(input bit wr, input logic [2:0] a, input logic [7:0] d);
    xfer_t x;
    x.wr = wr; x.addr = a; x.data = d; x.setup = cyc;
    cur = x;
    apb_exp.push_back(x);
    m_ph = 1;
  endtask

  task automatic start_gap();
    m_ph = 2;
    gap_end = cyc + GAP;
  endtask

  // Reference model: transaction-level behaviour of the poller plus the
  // UART register side effects (data pop, read-to-clear error register).
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        drop = m_cnt - ((rx_ready && m_cnt > 0) ? 1 : 0);
        for (int i = 0; i < drop; i++) if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_cnt = 0; m_err = 3'b000; m_cfg = 1'b0; m_ph = 0;
        apb_exp.delete();
        live = 1'b1;
      end else if (live) begin
        m_push = 0;
        m_pop  = (rx_ready && m_cnt > 0) ? 1 : 0;
        if (err_clear) m_err = 3'b000;
        case (m_ph)
          0: if (enable) sched(1'b1, 3'd2, 8'h0A);
          2: if (cyc == gap_end) begin
               if (enable) sched(1'b0, 3'd0, 8'h00);
               else m_ph = 0;
             end
          default: if (cyc == cur.setup + 2) begin
            if (inj_saterr) m_err[2] = 1'b1;
            case (cur.addr)
              3'd2: sched(1'b1, 3'd3, 8'h00);
              3'd3: sched(1'b1, 3'd4, 8'h08);
              3'd4: begin m_cfg = 1'b1; sched(1'b0, 3'd0, 8'h00); end
              3'd0: if (uart_q.size() > 0) sched(1'b0, 3'd1, 8'h00); else start_gap();
              3'd1: begin
                m_err[1:0] = m_err[1:0] | err_reg[1:0];
                err_reg = 8'h00;
                if (m_cnt < DEPTH) sched(1'b0, 3'd6, 8'h00); else start_gap();
              end
              default: begin
                if (uart_q.size() > 0) void'(uart_q.pop_front());
                m_push = 1;
                start_gap();
              end
            endcase
          end
        endcase
        m_cnt = m_cnt + m_push - m_pop;
      end
    end
  end

  // Subordinate read data and error response, driven during the access cycle.
  initial begin
    forever begin
      @(negedge clk);
      prdata  = 8'h00;
      psaterr = 1'b0;
      if (psel && penable) begin
        psaterr = inj_saterr;
        if (!pwrite) begin
          case (paddr)
            3'd0: prdata = 8'(uart_q.size() != 0);
            3'd1: prdata = err_reg;
            3'd6: if (uart_q.size() > 0) prdata = uart_q[0];
            default: ;
          endcase
        end
      end
    end
  end

  // Monitor: compares DUT outputs with the model away from the active edge.
  initial begin
    bit    e_sel, e_en;
    xfer_t front;
    forever begin
      @(negedge clk);
      if (live) begin
        e_sel = 1'b0; e_en = 1'b0;
        if (apb_exp.size() > 0) begin
          front = apb_exp[0];
          e_sel = (front.setup <= cyc);
          e_en  = e_sel && (cyc == front.setup + 1);
        end
        chk("status", 32'({psel, penable, busy, cfg_done, rx_valid, err_flags}),
            32'({e_sel, e_en, (m_ph != 0), m_cfg, (m_cnt > 0), m_err}));
        if (e_sel) begin
          if (front.wr) chk("bus_wr", 32'({pwrite, paddr, pwdata}), 32'({1'b1, front.addr, front.data}));
          else          chk("bus_rd", 32'({pwrite, paddr}), 32'({1'b0, front.addr}));
        end else begin
          chk("idle_bus", 32'({pwrite, paddr, pwdata}), 32'd0);
        end
        if (e_en) begin
          $display("apb %s addr=%0d wdata=%02h cyc=%0d", front.wr ? "wr" : "rd", front.addr, front.data, cyc);
          void'(apb_exp.pop_front());
        end
        if (m_cnt > 0 && rx_ready) begin
          if (exp_q.size() == 0) begin
            chk("byte_underflow", 32'(rx_byte), 32'hFFFF_FFFF);
          end else begin
            chk("rx_byte", 32'(rx_byte), 32'(exp_q[0]));
            $display("rx byte %02h cyc=%0d", exp_q[0], cyc);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic offer(input logic [7:0] b);
    uart_q.push_back(b);
    exp_q.push_back(b);
    $display("offer byte %02h cyc=%0d", b, cyc);
  endtask

  // Waits (bounded) for a transfer to addr a in SETUP (acc=0) or ACCESS (acc=1).
  task automatic wait_bus(input logic [2:0] a, input bit acc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (psel && (penable == acc) && (paddr == a)) ok = 1'b1;
    end
    chk("wait_bus", 32'(ok), 32'd1);
  endtask

  // Stimulus
  initial begin
    tick(3);
    rst = 1'b0;
    tick(3);
    // Config writes, then empty polls
    enable = 1'b1;
    tick(14);
    // Single byte, consumer ready
    rx_ready = 1'b1;
    offer(8'hA5);
    tick(30);
    // Back-pressure: four bytes fill the FIFO, fifth stays in the UART
    rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) offer(8'($urandom));
    tick(80);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(30);
    rx_ready = 1'b1;
    tick(30);
    // Error register read coinciding with err_clear, then a lone clear
    err_reg = 8'h03;
    offer(8'h3C);
    wait_bus(3'd1, 1'b1);
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    tick(6);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    tick(10);
    // Subordinate error on a status read
    wait_bus(3'd0, 1'b0);
    inj_saterr = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    inj_saterr = 1'b0;
    tick(12);
    // enable drops during RD_ERR: transfers and gap finish, then idle
    offer(8'h5A);
    wait_bus(3'd1, 1'b0);
    enable = 1'b0;
    tick(20);
    enable = 1'b1;
    tick(20);
    // Reset during the RD_DATA setup, then re-run config
    offer(8'hC3);
    wait_bus(3'd6, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tick(40);
    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 13) == 0) offer(8'($urandom));
      rx_ready   = ($urandom_range(0, 3) != 0);
      err_clear  = ($urandom_range(0, 19) == 0);
      inj_saterr = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 15) == 0) err_reg = err_reg | {6'b000000, 2'($urandom)};
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      tick(1);
    end
    // Drain everything still pending
    enable = 1'b1; rx_ready = 1'b1; err_clear = 1'b0; inj_saterr = 1'b0;
    for (int i = 0; i < 3000 && (uart_q.size() != 0 || exp_q.size() != 0); i++) tick(1);
    tick(5);
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
